// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle core's shared bus: byte-masked word RAM
// plus an MMIO page with a 64-bit cycle counter, a GPIO register and a console TX FIFO.
module mem_responder #(
    parameter int MEM_WORDS  = 1024,
    parameter     INIT_FILE  = "",
    parameter int CONS_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic [3:0]  WriteMask,
    output logic [31:0] ReadData,
    output logic [31:0] gpio_out,
    output logic        cons_valid,
    output logic [7:0]  cons_data,
    input  logic        cons_ready
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(CONS_DEPTH);

    localparam logic [5:0] OFF_CYCLE_LO = 6'd0;
    localparam logic [5:0] OFF_CYCLE_HI = 6'd1;
    localparam logic [5:0] OFF_GPIO     = 6'd2;
    localparam logic [5:0] OFF_CONS_TX  = 6'd3;
    localparam logic [5:0] OFF_STAT     = 6'd4;

    localparam logic [CW-1:0] PTR_ONE   = 1;
    localparam logic [CW:0]   CNT_ONE   = 1;
    localparam logic [CW:0]   CNT_FULL  = CONS_DEPTH[CW:0];

    // Lanes arrive pre-aligned, so the byte offset carries no information.
    logic unused_byte_off;
    assign unused_byte_off = ^Address[1:0];

    logic [29:0]   word_idx;
    logic [AW-1:0] ram_idx;
    logic [5:0]    off;
    logic          ram_hit, mmio_hit;

    assign word_idx = Address[31:2];
    assign ram_idx  = word_idx[AW-1:0];
    assign off      = Address[7:2];
    // word_idx < MEM_WORDS also implies Address[31] == 0
    assign ram_hit  = (word_idx < 30'(MEM_WORDS));
    assign mmio_hit = (Address[31:8] == 24'h800000);

    logic ram_we, gpio_we, push_req, ovf_clr;
    assign ram_we   = MemWrite && ram_hit;
    assign gpio_we  = MemWrite && mmio_hit && (off == OFF_GPIO);
    assign push_req = MemWrite && mmio_hit && (off == OFF_CONS_TX) && WriteMask[0];
    assign ovf_clr  = MemWrite && mmio_hit && (off == OFF_STAT) && WriteMask[0] && WriteData[2];

    // ---------------- RAM (contents survive reset) ----------------
    logic [31:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (ram_we)
            for (int i = 0; i < 4; i++)
                if (WriteMask[i]) mem[ram_idx][8*i +: 8] <= WriteData[8*i +: 8];
    end

    // ---------------- cycle counter and GPIO ----------------
    logic [63:0] cycle_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cycle_cnt <= '0;
        else       cycle_cnt <= cycle_cnt + 64'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_out <= '0;
        end else if (gpio_we) begin
            for (int i = 0; i < 4; i++)
                if (WriteMask[i]) gpio_out[8*i +: 8] <= WriteData[8*i +: 8];
        end
    end

    // ---------------- console TX FIFO ----------------
    logic [7:0]    fifo_mem [CONS_DEPTH];
    logic [CW-1:0] rd_ptr, wr_ptr;
    logic [CW:0]   fifo_cnt;
    logic          ovf, full, empty, pop, push_ok, ovf_set;

    assign full       = (fifo_cnt == CNT_FULL);
    assign empty      = (fifo_cnt == '0);
    assign cons_valid = !empty;
    assign cons_data  = empty ? 8'h00 : fifo_mem[rd_ptr];
    assign pop        = cons_valid && cons_ready;
    // A push into a full FIFO still lands if the head leaves on the same edge.
    assign push_ok    = push_req && (!full || pop);
    assign ovf_set    = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= WriteData[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
                2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (ovf_set)      ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

    // ---------------- read path ----------------
    logic [31:0] stat_word, rd_word;
    assign stat_word = {16'h0000, 8'(fifo_cnt), 5'b00000, ovf, empty, full};

    always_comb begin
        rd_word = 32'h0;
        if (ram_hit) begin
            rd_word = mem[ram_idx];
        end else if (mmio_hit) begin
            case (off)
                OFF_CYCLE_LO: rd_word = cycle_cnt[31:0];
                OFF_CYCLE_HI: rd_word = cycle_cnt[63:32];
                OFF_GPIO:     rd_word = gpio_out;
                OFF_STAT:     rd_word = stat_word;
                default:      rd_word = 32'h0;
            endcase
        end
    end

    // Sampled before this edge's write lands, giving read-before-write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ReadData <= '0;
        else       ReadData <= rd_word;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: RAM byte lanes, decode edges, MMIO, console FIFO, async reset.
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic [3:0]  WriteMask;
    logic [31:0] ReadData;
    logic [31:0] gpio_out;
    logic        cons_valid;
    logic [7:0]  cons_data;
    logic        cons_ready;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [31:0] A_CYC_LO = 32'h8000_0000;
    localparam logic [31:0] A_CYC_HI = 32'h8000_0004;
    localparam logic [31:0] A_GPIO   = 32'h8000_0008;
    localparam logic [31:0] A_TX     = 32'h8000_000C;
    localparam logic [31:0] A_STAT   = 32'h8000_0010;

    mem_responder #(.MEM_WORDS(1024), .INIT_FILE(""), .CONS_DEPTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .Address    (Address),
        .WriteData  (WriteData),
        .MemWrite   (MemWrite),
        .WriteMask  (WriteMask),
        .ReadData   (ReadData),
        .gpio_out   (gpio_out),
        .cons_valid (cons_valid),
        .cons_data  (cons_data),
        .cons_ready (cons_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        Address = a; WriteData = d; WriteMask = m; MemWrite = 1'b1;
        @(posedge clk); #1;
        MemWrite = 1'b0; WriteMask = 4'h0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        Address = a; MemWrite = 1'b0;
        @(posedge clk); #1;
        d = ReadData;
    endtask

    initial begin
        logic [31:0] r, c0, c1;
        reset = 1'b1; Address = '0; WriteData = '0; MemWrite = 1'b0;
        WriteMask = '0; cons_ready = 1'b0;
        #12;
        chk("rst_readdata", ReadData, 32'h0);
        chk("rst_gpio", gpio_out, 32'h0);
        chk("rst_valid", {31'h0, cons_valid}, 32'h0);
        chk("rst_data", {24'h0, cons_data}, 32'h0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        rd(A_STAT, r);  chk("stat_after_reset", r, 32'h0000_0002);

        // RAM byte lanes
        wr(32'h0000_0000, 32'h0BAD_F00D, 4'b1111);
        wr(32'h0000_0040, 32'hDEAD_BEEF, 4'b1111);
        wr(32'h0000_0040, 32'h00AA_0000, 4'b0100);
        rd(32'h0000_0040, r);  chk("ram_lane2", r, 32'hDEAA_BEEF);
        wr(32'h0000_0040, 32'hFFFF_FFFF, 4'b0000);
        rd(32'h0000_0040, r);  chk("ram_mask0", r, 32'hDEAA_BEEF);

        // read-before-write on the same word
        Address = 32'h0000_0040; WriteData = 32'h1234_5678; WriteMask = 4'hF; MemWrite = 1'b1;
        @(posedge clk); #1;
        chk("rbw_old", ReadData, 32'hDEAA_BEEF);
        MemWrite = 1'b0; WriteMask = 4'h0;
        @(posedge clk); #1;
        chk("rbw_new", ReadData, 32'h1234_5678);

        // decode boundaries
        wr(32'h0000_1000, 32'hFFFF_FFFF, 4'b1111);
        rd(32'h0000_1000, r);  chk("beyond_ram", r, 32'h0);
        rd(32'h0000_0000, r);  chk("no_alias_w0", r, 32'h0BAD_F00D);
        rd(32'h8000_0014, r);  chk("mmio_hole", r, 32'h0);
        rd(A_TX, r);           chk("cons_tx_read", r, 32'h0);
        rd(A_CYC_HI, r);       chk("cycle_hi", r, 32'h0);
        Address = A_CYC_LO;
        @(posedge clk); #1; c0 = ReadData;
        @(posedge clk); #1; c1 = ReadData;
        chk("cycle_step", c1 - c0, 32'h1);

        // GPIO
        wr(A_GPIO, 32'hCAFE_1234, 4'b1111);
        chk("gpio_full", gpio_out, 32'hCAFE_1234);
        wr(A_GPIO, 32'hFFFF_56FF, 4'b0010);
        rd(A_GPIO, r);         chk("gpio_lane1", r, 32'hCAFE_5634);

        // FIFO fill and overflow
        for (int i = 0; i < 16; i++) wr(A_TX, 32'h41 + i, 4'b0001);
        chk("fill_head", {24'h0, cons_data}, 32'h41);
        rd(A_STAT, r);         chk("stat_full", r, 32'h0000_1001);
        wr(A_TX, 32'h99, 4'b0001);
        rd(A_STAT, r);         chk("stat_ovf", r, 32'h0000_1005);
        wr(A_STAT, 32'h4, 4'b0001);
        rd(A_STAT, r);         chk("stat_ovf_clr", r, 32'h0000_1001);

        // full with simultaneous push and pop
        Address = A_TX; WriteData = 32'h5A; WriteMask = 4'b0001; MemWrite = 1'b1; cons_ready = 1'b1;
        @(posedge clk); #1;
        MemWrite = 1'b0; WriteMask = 4'h0; cons_ready = 1'b0;
        chk("pushpop_head", {24'h0, cons_data}, 32'h42);
        rd(A_STAT, r);         chk("pushpop_stat", r, 32'h0000_1001);
        for (int k = 0; k < 16; k++) begin
            chk("drain", {24'h0, cons_data}, (k < 15) ? 32'h42 + k : 32'h5A);
            cons_ready = 1'b1;
            @(posedge clk); #1;
            cons_ready = 1'b0;
        end
        chk("drained_valid", {31'h0, cons_valid}, 32'h0);
        chk("drained_data", {24'h0, cons_data}, 32'h0);

        // async reset with bytes queued
        for (int i = 0; i < 5; i++) wr(A_TX, 32'h61 + i, 4'b0001);
        rd(A_STAT, r);         chk("stat_five", r, 32'h0000_0500);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", {31'h0, cons_valid}, 32'h0);
        chk("arst_readdata", ReadData, 32'h0);
        chk("arst_gpio", gpio_out, 32'h0);
        @(negedge clk); reset = 1'b0;
        rd(A_STAT, r);         chk("stat_post_reset", r, 32'h0000_0002);
        rd(32'h0000_0040, r);  chk("ram_kept_40", r, 32'h1234_5678);
        rd(32'h0000_0000, r);  chk("ram_kept_0", r, 32'h0BAD_F00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
